nibble_unpack_fifo: RTL and testbench

NIBBLE_UNPACK_FIFO -- requirements
Module: nibble_unpack_fifo

---
 rtl/nibble_unpack_pkg.sv | 16 +
 rtl/nibble_unpack_if.sv | 31 +++
 rtl/nibble_unpack_ram.sv | 25 ++
 rtl/nibble_unpack_fifo.sv | 76 +++++++
 tb/tb_nibble_unpack_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_unpack_pkg.sv
// Shared widths and defaults for the nibble unpack FIFO.
// Nibble order option: NIBBLE_UNPACK_MSN_FIRST_EN.
package nibble_unpack_pkg;

  localparam int BYTE_W    = 8;
  localparam int NIB_W     = 4;
  localparam int DEPTH_DEF = 8;

  function automatic logic [NIB_W-1:0] nib_sel(
    input logic [BYTE_W-1:0] b,
    input logic              hi
  );
    return hi ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/nibble_unpack_if.sv
// Byte-in / nibble-out valid-ready handshake bundle.
// Nibble order option: NIBBLE_UNPACK_MSN_FIRST_EN.
interface nibble_unpack_if;
  import nibble_unpack_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NIB_W-1:0]  out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/nibble_unpack_ram.sv
// Byte storage: sync write, async read, no reset.
// Nibble order option: NIBBLE_UNPACK_MSN_FIRST_EN.
module nibble_unpack_ram
  import nibble_unpack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_unpack_fifo.sv
// Byte FIFO that hands bytes out as two nibbles.
// NIBBLE_UNPACK_MSN_FIRST_EN: emit high nibble first.
module nibble_unpack_fifo
  import nibble_unpack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  nibble_unpack_if.slave bus,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

`ifdef NIBBLE_UNPACK_MSN_FIRST_EN
  localparam logic MSN_FIRST = 1'b1;
`else
  localparam logic MSN_FIRST = 1'b0;
`endif

  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              half;
  logic              wr_en;
  logic              rd_en;
  logic              retire;
  logic [BYTE_W-1:0] rd_byte;

  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

  // Handshakes come from registered level only.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  assign wr_en  = bus.in_valid && !full;
  assign rd_en  = bus.out_ready && !empty;
  assign retire = rd_en && half;

  nibble_unpack_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  assign bus.out_data = nib_sel(rd_byte, half ^ MSN_FIRST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      half   <= 1'b0;
      level  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)  half   <= !half;
      if (retire) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        wr_en && !retire: level <= level + (AW+1)'(1);
        !wr_en && retire: level <= level - (AW+1)'(1);
        default:          level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_unpack_fifo.sv
// Randomised and directed checks of nibble_unpack_fifo against a queue model.
// Nibble order option: NIBBLE_UNPACK_MSN_FIRST_EN.
module tb_nibble_unpack_fifo;
  import nibble_unpack_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

`ifdef NIBBLE_UNPACK_MSN_FIRST_EN
  localparam bit MSN = 1'b1;
`else
  localparam bit MSN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic        empty;
  logic [AW:0] level;

  nibble_unpack_if bus ();

  nibble_unpack_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: stored bytes in order, plus which nibble of the head is next.
  logic [7:0] q[$];
  bit         m_half = 1'b0;
  bit         m_live = 1'b0;

  function automatic int model_nib();
    logic [7:0] b;
    b = q[0];
    return (m_half ^ MSN) ? int'(b[7:4]) : int'(b[3:0]);
  endfunction

  always @(posedge clk) begin
    bit wr;
    bit rd;
    if (rst) begin
      q.delete();
      m_half = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      wr = bus.in_valid && (q.size() < DEPTH);
      rd = bus.out_ready && (q.size() > 0);
      if (rd) begin
        if (m_half) begin
          void'(q.pop_front());
          m_half = 1'b0;
        end else begin
          m_half = 1'b1;
        end
      end
      if (wr) q.push_back(bus.in_data);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("level", int'(level), q.size());
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("in_ready", int'(bus.in_ready), int'(q.size() != DEPTH));
      chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
      if (q.size() > 0) chk("out_data", int'(bus.out_data), model_nib());
    end
  end

  task automatic step(input bit r, input bit iv, input logic [7:0] d, input bit ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && !empty; i++) step(0, 0, 8'h00, 1);
    chk("drain_empty", int'(empty), 1);
  endtask

  function automatic int first_nib(input logic [7:0] b, input int k);
    return ((k != 0) ^ MSN) ? int'(b[7:4]) : int'(b[3:0]);
  endfunction

  int exp34 [4];
  int lv34  [4];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
`ifdef NIBBLE_UNPACK_MSN_FIRST_EN
    exp34 = '{4'hA, 4'h5, 4'h3, 4'hC};
`else
    exp34 = '{4'h5, 4'hA, 4'hC, 4'h3};
`endif
    lv34 = '{2, 1, 1, 0};

    step(1, 1, 8'hFF, 1);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);

    // Basic order
    step(0, 1, 8'hA5, 0);
    step(0, 1, 8'h3C, 0);
    chk("basic_level", int'(level), 2);
    for (int i = 0; i < 4; i++) begin
      chk("basic_data", int'(bus.out_data), exp34[i]);
      step(0, 0, 8'h00, 1);
      chk("basic_lvl_seq", int'(level), lv34[i]);
    end
    chk("basic_empty", int'(empty), 1);

    // Full and wrap
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h10 + i), 0);
    chk("full_flag", int'(full), 1);
    chk("full_in_ready", int'(bus.in_ready), 0);
    step(0, 1, 8'hFF, 0);
    chk("full_ignored", int'(level), DEPTH);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      chk("wrap_data", int'(bus.out_data), first_nib(8'(8'h10 + i / 2), i % 2));
      step(0, 0, 8'h00, 1);
    end
    chk("wrap_empty", int'(empty), 1);
    step(0, 1, 8'h99, 0);
    chk("wrap_99a", int'(bus.out_data), 9);
    step(0, 0, 8'h00, 1);
    chk("wrap_99b", int'(bus.out_data), 9);
    step(0, 0, 8'h00, 1);

    // Simultaneous while full
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h20 + i), 0);
    step(0, 1, 8'hEE, 1);
    chk("sim_full_lvl_a", int'(level), DEPTH);
    step(0, 1, 8'hEE, 1);
    chk("sim_full_lvl_b", int'(level), DEPTH - 1);
    chk("sim_full_rdy", int'(bus.in_ready), 1);
    step(0, 1, 8'hEE, 0);
    chk("sim_full_lvl_c", int'(level), DEPTH);
    drain();

    // Simultaneous at level 1
    step(0, 1, 8'h4D, 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h6B, 1);
    chk("sim_lvl1", int'(level), 1);
    chk("sim_lvl1_data", int'(bus.out_data), first_nib(8'h6B, 0));
    drain();

    // Empty and latency
    step(0, 1, 8'h7E, 1);
    chk("lat_valid", int'(bus.out_valid), 1);
    chk("lat_first", int'(bus.out_data), first_nib(8'h7E, 0));
    step(0, 0, 8'h00, 1);
    chk("lat_second", int'(bus.out_data), first_nib(8'h7E, 1));
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'hC3, 0);
    chk("lat_no_ptr_move", int'(bus.out_data), first_nib(8'hC3, 0));
    drain();

    // Reset mid-byte
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_level", int'(level), 0);
    step(0, 1, 8'h21, 0);
    chk("mid_rst_first", int'(bus.out_data), first_nib(8'h21, 0));
    step(0, 0, 8'h00, 1);
    chk("mid_rst_second", int'(bus.out_data), first_nib(8'h21, 1));
    step(0, 0, 8'h00, 1);

    // Random traffic with phases biased towards filling and draining
    for (int i = 0; i < 3000; i++) begin
      int p_in;
      p_in = ((i / 150) % 2 == 0) ? 80 : 30;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < p_in,
           8'($urandom),
           $urandom_range(0, 99) >= p_in);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
